// File: rtl/bch_enc_arbiter.sv
// Round-robin front end for one shared BCH encoder: two valid/ready message
// sources, a registered encoder operand, latency wait, and a held codeword output.
module bch_enc_arbiter #(
  parameter int K       = 63,
  parameter int N       = 75,
  parameter int ENC_LAT = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [K-1:0]     req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [K-1:0]     req1_data,
  output logic             req1_ready,
  output logic [K-1:0]     enc_in,
  input  logic [N-1:0]     enc_out,
  output logic             out_valid,
  output logic [N-1:0]     out_data,
  output logic             out_id,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_issued
);

  // Wait counter needs at least one bit even for a combinational encoder.
  localparam int LAT_W = (ENC_LAT > 0) ? $clog2(ENC_LAT + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t           state_q;
  logic [K-1:0]     enc_in_q;
  logic [N-1:0]     out_data_q;
  logic             out_id_q;
  logic             out_valid_q;
  logic             id_q;
  logic             last_grant_q;
  logic [CNT_W-1:0] cnt_q;
  logic [LAT_W-1:0] wait_q;
  logic             grant0;
  logic             grant1;

  // On contention the requester that did not win last time is served.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      enc_in_q     <= '0;
      out_data_q   <= '0;
      out_id_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      wait_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant0 || grant1) begin
            enc_in_q     <= grant1 ? req1_data : req0_data;
            id_q         <= grant1;
            last_grant_q <= grant1;
            wait_q       <= LAT_W'(ENC_LAT);
            state_q      <= WAIT;
          end
        end
        WAIT: begin
          if (wait_q != '0) begin
            wait_q <= wait_q - LAT_W'(1);
          end else begin
            out_data_q  <= enc_out;
            out_id_q    <= id_q;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            cnt_q       <= cnt_q + CNT_W'(1);
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign enc_in     = enc_in_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_id     = out_id_q;
  assign busy       = (state_q != IDLE);
  assign cnt_issued = cnt_q;

endmodule

// File: tb/tb_bch_enc_arbiter.sv
// Bench for bch_enc_arbiter: a combinational-encoder instance (4-bit counter) with a
// codeword scoreboard, and a 3-cycle pipelined-encoder instance for latency checks.
module tb_bch_enc_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  function automatic logic [74:0] bch_model(input logic [62:0] m);
    logic [11:0] r;
    logic        fb;
    r = '0;
    for (int i = 62; i >= 0; i--) begin
      fb = m[i] ^ r[11];
      r  = {r[10:0], 1'b0};
      if (fb) r = r ^ 12'h539;
    end
    return {m, r};
  endfunction

  logic        a_req0_valid = 1'b0, a_req1_valid = 1'b0, a_out_ready = 1'b0;
  logic [62:0] a_req0_data = '0, a_req1_data = '0;
  logic        a_req0_ready, a_req1_ready, a_out_valid, a_out_id, a_busy;
  logic [62:0] a_enc_in;
  logic [74:0] a_enc_out, a_out_data;
  logic [3:0]  a_cnt;

  assign a_enc_out = bch_model(a_enc_in);

  bch_enc_arbiter #(.K(63), .N(75), .ENC_LAT(0), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(a_req0_valid), .req0_data(a_req0_data), .req0_ready(a_req0_ready),
    .req1_valid(a_req1_valid), .req1_data(a_req1_data), .req1_ready(a_req1_ready),
    .enc_in(a_enc_in), .enc_out(a_enc_out),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_id(a_out_id),
    .out_ready(a_out_ready), .busy(a_busy), .cnt_issued(a_cnt)
  );

  logic        b_req0_valid = 1'b0, b_req1_valid = 1'b0, b_out_ready = 1'b0;
  logic [62:0] b_req0_data = '0, b_req1_data = '0;
  logic        b_req0_ready, b_req1_ready, b_out_valid, b_out_id, b_busy;
  logic [62:0] b_enc_in;
  logic [74:0] b_enc_out, b_out_data;
  logic [15:0] b_cnt;
  logic [74:0] b_p1 = '0, b_p2 = '0, b_p3 = '0;

  always @(posedge clk) begin
    b_p1 <= bch_model(b_enc_in);
    b_p2 <= b_p1;
    b_p3 <= b_p2;
  end
  assign b_enc_out = b_p3;

  bch_enc_arbiter #(.K(63), .N(75), .ENC_LAT(3), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
    .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_ready(b_req1_ready),
    .enc_in(b_enc_in), .enc_out(b_enc_out),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_id(b_out_id),
    .out_ready(b_out_ready), .busy(b_busy), .cnt_issued(b_cnt)
  );

  logic [75:0] sb_a[$];
  logic [75:0] sb_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_a.delete();
    end else begin
      if (a_out_valid && a_out_ready) begin
        checks++;
        if (sb_a.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_output: got id=%0b data=%h, expected no codeword", a_out_id, a_out_data);
        end else begin
          sb_exp = sb_a.pop_front();
          if ({a_out_id, a_out_data} !== sb_exp) begin
            errors++;
            $display("FAIL sb_codeword: got id=%0b data=%h, expected id=%0b data=%h",
                     a_out_id, a_out_data, sb_exp[75], sb_exp[74:0]);
          end
        end
      end
      if (a_req0_valid && a_req0_ready) sb_a.push_back({1'b0, bch_model(a_req0_data)});
      if (a_req1_valid && a_req1_ready) sb_a.push_back({1'b1, bch_model(a_req1_data)});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", a_out_valid); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", a_busy); end
    checks++; if (a_enc_in !== 63'd0) begin errors++; $display("FAIL reset_enc_in: got %h expected 0", a_enc_in); end
    checks++; if (a_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", a_cnt); end
    checks++; if ({a_out_id, a_out_data} !== 76'd0) begin errors++; $display("FAIL reset_out_data: got id=%0b data=%h expected 0", a_out_id, a_out_data); end
    checks++; if (b_out_valid !== 1'b0 || b_cnt !== 16'd0) begin errors++; $display("FAIL reset_b: got valid=%0b cnt=%0d expected 0/0", b_out_valid, b_cnt); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    a_out_ready = 1'b1;
    a_req0_data = 63'd5;
    a_req0_valid = 1'b1;
    #1;
    checks++; if (a_req0_ready !== 1'b1 || a_req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready: got r0=%0b r1=%0b expected 1/0", a_req0_ready, a_req1_ready); end
    tick();
    a_req0_valid = 1'b0;
    checks++; if (a_enc_in !== 63'd5 || a_busy !== 1'b1 || a_out_valid !== 1'b0) begin errors++; $display("FAIL single_wait: got enc_in=%0d busy=%0b ov=%0b expected 5/1/0", a_enc_in, a_busy, a_out_valid); end
    tick();
    checks++; if (a_out_valid !== 1'b1 || a_out_id !== 1'b0 || a_out_data !== bch_model(63'd5)) begin errors++; $display("FAIL single_out: got ov=%0b id=%0b data=%h expected 1/0/%h", a_out_valid, a_out_id, a_out_data, bch_model(63'd5)); end
    tick();
    checks++; if (a_out_valid !== 1'b0 || a_cnt !== 4'd1 || a_busy !== 1'b0) begin errors++; $display("FAIL single_done: got ov=%0b cnt=%0d busy=%0b expected 0/1/0", a_out_valid, a_cnt, a_busy); end
  endtask

  task automatic test_alternate;
    int seen = 0;
    int guard = 0;
    logic exp_id;
    do_reset();
    a_out_ready = 1'b1;
    a_req0_data = 63'd1;
    a_req1_data = 63'd2;
    a_req0_valid = 1'b1;
    a_req1_valid = 1'b1;
    while (seen < 6 && guard < 100) begin
      tick();
      guard++;
      if (a_out_valid) begin
        exp_id = seen[0];
        checks++; if (a_out_id !== exp_id) begin errors++; $display("FAIL alt_id[%0d]: got %0b expected %0b", seen, a_out_id, exp_id); end
        checks++; if (a_out_data !== bch_model(exp_id ? 63'd2 : 63'd1)) begin errors++; $display("FAIL alt_data[%0d]: got %h expected %h", seen, a_out_data, bch_model(exp_id ? 63'd2 : 63'd1)); end
        seen++;
        if (seen == 6) begin
          a_req0_valid = 1'b0;
          a_req1_valid = 1'b0;
        end
      end
    end
    checks++; if (seen != 6) begin errors++; $display("FAIL alt_timeout: got %0d codewords expected 6", seen); end
    a_req0_valid = 1'b0;
    a_req1_valid = 1'b0;
    tick();
    checks++; if (a_cnt !== 4'd6 || a_busy !== 1'b0) begin errors++; $display("FAIL alt_cnt: got cnt=%0d busy=%0b expected 6/0", a_cnt, a_busy); end
  endtask

  task automatic test_backpressure;
    logic ok = 1'b1;
    a_out_ready = 1'b0;
    a_req0_data = 63'd7;
    a_req0_valid = 1'b1;
    #1;
    checks++; if (a_req0_ready !== 1'b1) begin errors++; $display("FAIL bp_accept0: got %0b expected 1", a_req0_ready); end
    tick();
    a_req0_valid = 1'b0;
    tick();
    a_req1_data = 63'd3;
    a_req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      if (a_out_valid !== 1'b1 || a_out_id !== 1'b0 || a_out_data !== bch_model(63'd7) ||
          a_req1_ready !== 1'b0 || a_busy !== 1'b1) begin
        if (ok) $display("FAIL bp_hold[%0d]: got ov=%0b id=%0b data=%h r1=%0b busy=%0b expected 1/0/%h/0/1",
                         i, a_out_valid, a_out_id, a_out_data, a_req1_ready, a_busy, bch_model(63'd7));
        ok = 1'b0;
      end
      tick();
    end
    checks++; if (!ok) errors++;
    a_out_ready = 1'b1;
    #1;
    checks++; if (a_req1_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_in_hold: got %0b expected 0", a_req1_ready); end
    tick();
    checks++; if (a_req1_ready !== 1'b1 || a_out_valid !== 1'b0 || a_cnt !== 4'd7) begin errors++; $display("FAIL bp_release: got r1=%0b ov=%0b cnt=%0d expected 1/0/7", a_req1_ready, a_out_valid, a_cnt); end
    tick();
    a_req1_valid = 1'b0;
    checks++; if (a_enc_in !== 63'd3) begin errors++; $display("FAIL bp_enc_in: got %0d expected 3", a_enc_in); end
    tick();
    checks++; if (a_out_valid !== 1'b1 || a_out_id !== 1'b1) begin errors++; $display("FAIL bp_out1: got ov=%0b id=%0b expected 1/1", a_out_valid, a_out_id); end
    tick();
    checks++; if (a_cnt !== 4'd8) begin errors++; $display("FAIL bp_cnt: got %0d expected 8", a_cnt); end
  endtask

  task automatic test_latency;
    int guard = 0;
    b_out_ready = 1'b1;
    b_req0_data = 63'h123;
    b_req0_valid = 1'b1;
    tick();
    b_req0_valid = 1'b0;
    while (!b_out_valid && guard < 20) begin tick(); guard++; end
    checks++; if (!b_out_valid) begin errors++; $display("FAIL lat_prime_timeout: got ov=0 expected 1 within 20 cycles"); end
    tick();
    b_req0_data = 63'd9;
    b_req0_valid = 1'b1;
    #1;
    checks++; if (b_req0_ready !== 1'b1) begin errors++; $display("FAIL lat_accept: got %0b expected 1", b_req0_ready); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      b_req0_valid = 1'b0;
      checks++; if (b_out_valid !== 1'b0 || b_enc_in !== 63'd9) begin errors++; $display("FAIL lat_wait[T+%0d]: got ov=%0b enc_in=%h expected 0/9", k, b_out_valid, b_enc_in); end
    end
    tick();
    checks++; if (b_out_valid !== 1'b1 || b_out_id !== 1'b0 || b_out_data !== bch_model(63'd9)) begin errors++; $display("FAIL lat_out[T+5]: got ov=%0b id=%0b data=%h expected 1/0/%h", b_out_valid, b_out_id, b_out_data, bch_model(63'd9)); end
    tick();
    checks++; if (b_cnt !== 16'd2 || b_busy !== 1'b0) begin errors++; $display("FAIL lat_cnt: got cnt=%0d busy=%0b expected 2/0", b_cnt, b_busy); end
  endtask

  task automatic test_reset_mid_wait;
    int guard = 0;
    a_out_ready = 1'b1;
    a_req0_data = 63'h55;
    a_req0_valid = 1'b1;
    tick();
    a_req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_enc_in !== 63'd0 || a_cnt !== 4'd0) begin errors++; $display("FAIL midrst: got ov=%0b busy=%0b enc_in=%h cnt=%0d expected 0/0/0/0", a_out_valid, a_busy, a_enc_in, a_cnt); end
    tick();
    rst_n = 1'b1;
    tick();
    a_req0_data = 63'h11;
    a_req1_data = 63'h22;
    a_req0_valid = 1'b1;
    a_req1_valid = 1'b1;
    #1;
    checks++; if (a_req0_ready !== 1'b1 || a_req1_ready !== 1'b0) begin errors++; $display("FAIL midrst_first_grant: got r0=%0b r1=%0b expected 1/0", a_req0_ready, a_req1_ready); end
    tick();
    a_req0_valid = 1'b0;
    while (!a_out_valid && guard < 20) begin tick(); guard++; end
    checks++; if (a_out_valid !== 1'b1 || a_out_id !== 1'b0) begin errors++; $display("FAIL midrst_out0: got ov=%0b id=%0b expected 1/0", a_out_valid, a_out_id); end
    tick();
    guard = 0;
    while (!a_out_valid && guard < 20) begin tick(); guard++; end
    a_req1_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1 || a_out_id !== 1'b1) begin errors++; $display("FAIL midrst_out1: got ov=%0b id=%0b expected 1/1", a_out_valid, a_out_id); end
    tick();
    checks++; if (a_cnt !== 4'd2) begin errors++; $display("FAIL midrst_cnt: got %0d expected 2", a_cnt); end
    do_reset();
    a_req1_data = 63'h33;
    a_req1_valid = 1'b1;
    #1;
    checks++; if (a_req1_ready !== 1'b1 || a_req0_ready !== 1'b0) begin errors++; $display("FAIL rst_req1_alone: got r0=%0b r1=%0b expected 0/1", a_req0_ready, a_req1_ready); end
    tick();
    a_req1_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_wrap;
    int seen = 0;
    int guard = 0;
    do_reset();
    a_out_ready = 1'b1;
    a_req0_data = 63'h3F;
    a_req0_valid = 1'b1;
    while (seen < 17 && guard < 200) begin
      tick();
      guard++;
      if (a_out_valid) begin
        seen++;
        if (seen == 17) begin
          a_req0_valid = 1'b0;
          checks++; if (a_cnt !== 4'd0) begin errors++; $display("FAIL wrap_at16: got %0d expected 0", a_cnt); end
        end
      end
    end
    a_req0_valid = 1'b0;
    checks++; if (seen != 17) begin errors++; $display("FAIL wrap_timeout: got %0d codewords expected 17", seen); end
    tick();
    checks++; if (a_cnt !== 4'd1) begin errors++; $display("FAIL wrap_cnt: got %0d expected 1", a_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_latency();
    test_reset_mid_wait();
    test_wrap();
    tick();
    checks++; if (sb_a.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending codewords expected 0", sb_a.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bch_enc_arbiter.md
Name: bch_enc_arbiter

Overview:
Shares one 63-to-75-bit BCH encoder (enc_top) between two requesters. Each requester offers a 63-bit message on a valid/ready handshake. The block round-robin arbitrates between them, drives the encoder operand from a register, and waits a configurable encoder latency. It then captures the 75-bit codeword with the winner's ID and presents it on a valid/ready output. It sits between the message sources and the codeword sink; enc_top is instantiated outside and wired to enc_in/enc_out.

Parameters:
K, 63, message width (encoder IN width)
N, 75, codeword width (encoder OUT width)
ENC_LAT, 0, encoder pipeline latency in clk cycles (0 = combinational enc_top)
CNT_W, 16, width of issued-codeword counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has a message
req0_data  input  K  requester 0 message
req0_ready  output  1  requester 0 message accepted this cycle when valid&ready
req1_valid  input  1  requester 1 has a message
req1_data  input  K  requester 1 message
req1_ready  output  1  requester 1 message accepted this cycle when valid&ready
enc_in  output  K  operand to shared encoder (registered)
enc_out  input  N  codeword from shared encoder
out_valid  output  1  codeword available
out_data  output  N  captured codeword
out_id  output  1  requester that produced out_data
out_ready  input  1  sink accepts codeword when out_valid&out_ready
busy  output  1  high in WAIT or HOLD
cnt_issued  output  CNT_W  codewords delivered since reset, wraps at 2^CNT_W

Behaviour:
- Reset (async, rst_n=0): state=IDLE, enc_in=0, out_valid=0, out_data=0, out_id=0, busy=0, cnt_issued=0, last_grant=1 (so requester 0 wins first), wait counter=0. All registers are clean on release; mid-operation reset discards any in-flight message and codeword.
- FSM states: IDLE, WAIT, HOLD.
- IDLE:
  - reqX_ready = grant_X; ready is low in all other states.
  - Grant when exactly one valid: that requester.
  - Grant when both valid: the one not equal to last_grant.
  - On grant edge: enc_in <= granted data, id_q <= granted index, last_grant <= granted index, counter <= ENC_LAT, state -> WAIT.
  - No valid: stay in IDLE.
  - ready is a combinational function of valid/state; a requester must not drop valid before acceptance.
- WAIT:
  - enc_in is held stable.
  - Counter > 0: decrement.
  - Counter == 0: out_data <= enc_out, out_id <= id_q, out_valid <= 1, state -> HOLD.
  - With ENC_LAT=0, WAIT lasts exactly 1 cycle.
- HOLD:
  - out_valid=1; out_data and out_id are stable until handshake.
  - On out_valid&out_ready: out_valid <= 0, cnt_issued <= cnt_issued+1 (modulo), state -> IDLE.
  - No new message is accepted in HOLD; there is no overlap.
- Latency: message accepted in cycle T -> out_valid high from cycle T+ENC_LAT+2.
- Throughput: at best one codeword every ENC_LAT+3 cycles (IDLE, WAIT×(ENC_LAT+1), HOLD with immediate ready).
- enc_in retains the last operand after HOLD; it is not cleared.
- busy = (state != IDLE).
- Backpressure: an indefinite out_ready=0 holds HOLD forever. Both reqX_ready stay 0 during this time.
- Fairness: under continuous valid on both inputs, grants alternate 0,1,0,1…; no requester starves.

Test Plan:
- Reset then single request: req0_valid=1, data=63'd5, ENC_LAT=0, out_ready=1. Required response:
  - req0_ready=1 in cycle T.
  - enc_in=5 from T+1.
  - out_valid=1 at T+2 with out_data = model BCH(5) and out_id=0.
  - cnt_issued=1 after the handshake.
- Both requesters continuously valid, data 63'd1 and 63'd2, 6 messages. Required response:
  - out_id sequence 0,1,0,1,0,1.
  - Codewords match BCH(1)/BCH(2).
  - cnt_issued=6.
- Backpressure: out_ready=0 for 10 cycles during HOLD with req1_valid=1. Required response:
  - out_valid, out_data and out_id remain constant.
  - req1_ready stays 0.
  - After out_ready=1, return to IDLE and accept req1 next cycle.
- ENC_LAT=3 with a delayed encoder model: message 63'd9 accepted at T. Required response:
  - out_valid at T+5.
  - Captured value is BCH(9), not the value present before the operand settled.
- Reset mid-WAIT: assert rst_n=0 one cycle after accept. Required response:
  - out_valid=0, busy=0, enc_in=0, cnt_issued=0 immediately.
  - After release, a new req1 message is granted first only if req0 is idle; otherwise req0 wins.
- Counter wrap with CNT_W=4: 17 deliveries -> cnt_issued=1.
